// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter
//
// Purpose:
//    Multi-digit BCD up/down counter that advances by one every DIV enabled
//    clock cycles. An internal prescaler counts enabled cycles. When it
//    reaches DIV-1, the count steps by one in BCD, tick_o pulses, and
//    finish_o pulses if the step wrapped past the limit.
//
// Configuration:
//    BCD_COUNTER_SATURATE_EN  When defined, a step at the limit holds the
//                             count (all-9s going up, 0 going down) instead
//                             of wrapping. tick_o and finish_o still pulse
//                             on such a step. When undefined (the default
//                             build), the count wraps.
//
// Ports:
//    clk_i       system clock; all state updates on the rising edge
//    reset_i     synchronous, active-low reset
//    enable_i    high advances the prescaler; low freezes prescaler and count
//    forward_i   high counts up, low counts down; sampled on the step cycle
//    load_i      one-cycle load request; has priority over a step
//    load_val_i  BCD value to load (digit 0 in [3:0]); digits > 9 clamp to 9
//    count_o     current BCD count (registered)
//    tick_o      one-cycle pulse on each count step (registered)
//    finish_o    one-cycle pulse on a wrap or limit step (registered)
module bcd_tick_counter #(
    parameter int DIGITS = 2,
    parameter int DIV    = 50000000,
    parameter int DIV_W  = 26
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  forward_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  tick_o,
    output logic                  finish_o
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0]    presc_q, presc_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic                tick_q, tick_d;
    logic                finish_q, finish_d;

    logic [4*DIGITS-1:0] incVal, decVal, clampVal;
    logic                atMax, atMin, step, atLimit;

    // The increment and decrement values are built with a ripple
    // carry/borrow across the digits. A carry out of the top digit means
    // every digit was 9. A borrow out of the top digit means every digit
    // was 0. Those two flags are reused as the limit detectors. The clamp
    // forces any non-BCD load digit to 9, so the count never holds a
    // non-BCD digit.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] digit;
        incVal   = '0;
        decVal   = '0;
        clampVal = '0;
        carry    = 1'b1;
        borrow   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                incVal[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                carry            = (digit == 4'd9);
            end else begin
                incVal[4*i +: 4] = digit;
            end
            if (borrow) begin
                decVal[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                borrow           = (digit == 4'd0);
            end else begin
                decVal[4*i +: 4] = digit;
            end
            clampVal[4*i +: 4] = (load_val_i[4*i +: 4] > 4'd9) ? 4'd9
                                                                : load_val_i[4*i +: 4];
        end
        atMax = carry;
        atMin = borrow;
    end

    assign step    = enable_i && (presc_q == PRESC_LAST);
    assign atLimit = forward_i ? atMax : atMin;

    // Next-state logic. A load wins over a step and restarts the prescale
    // interval, so the first step after a load is a full DIV enabled
    // cycles later. While enable_i is low, everything holds and the
    // pulses drop.
    always_comb begin
        presc_d  = presc_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        finish_d = 1'b0;
        if (load_i) begin
            presc_d = '0;
            count_d = clampVal;
        end else if (enable_i) begin
            if (step) begin
                presc_d  = '0;
                tick_d   = 1'b1;
                finish_d = atLimit;
`ifdef BCD_COUNTER_SATURATE_EN
                if (!atLimit) begin
                    count_d = forward_i ? incVal : decVal;
                end
`else
                count_d = forward_i ? incVal : decVal;
`endif
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end
    end

    // State registers. Reset discards any partial interval, so the next
    // step comes DIV enabled cycles after reset is released.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            presc_q  <= '0;
            count_q  <= '0;
            tick_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            count_q  <= count_d;
            tick_q   <= tick_d;
            finish_q <= finish_d;
        end
    end

    assign count_o  = count_q;
    assign tick_o   = tick_q;
    assign finish_o = finish_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb_bcd_tick_counter
//
// Directed bench for bcd_tick_counter with DIGITS=2 and DIV=4. Inputs
// change 1 time unit after each rising edge, and outputs are sampled at
// that same point.
module tb_bcd_tick_counter;

    localparam int DIGITS = 2;
    localparam int DIV    = 4;
    localparam int DIV_W  = 3;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic       forward_i;
    logic       load_i;
    logic [7:0] load_val_i;
    logic [7:0] count_o;
    logic       tick_o;
    logic       finish_o;

    int vectors     = 0;
    int miscompares = 0;

    bcd_tick_counter #(
        .DIGITS(DIGITS),
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .enable_i  (enable_i),
        .forward_i (forward_i),
        .load_i    (load_i),
        .load_val_i(load_val_i),
        .count_o   (count_o),
        .tick_o    (tick_o),
        .finish_o  (finish_o)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just past the edge.
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Load a value with a one-cycle pulse and check the loaded count.
    task automatic applyStimulus(input string tag, input logic [7:0] val,
                                 input logic [7:0] expCount);
        load_i     = 1'b1;
        load_val_i = val;
        cycle();
        load_i     = 1'b0;
        checkOutput({tag, " load count"}, count_o, expCount);
        checkOutput({tag, " load tick"}, tick_o, 0);
    endtask

    // Run one full interval: three quiet cycles, then the step edge.
    task automatic stepAndCheck(input string tag, input logic [7:0] expCount,
                                input logic expFinish);
        for (int i = 0; i < DIV - 1; i++) begin
            cycle();
            checkOutput({tag, " quiet tick"}, tick_o, 0);
        end
        cycle();
        checkOutput({tag, " step tick"}, tick_o, 1);
        checkOutput({tag, " step count"}, count_o, expCount);
        checkOutput({tag, " step finish"}, finish_o, expFinish);
    endtask

    initial begin
        reset_i    = 1'b0;
        enable_i   = 1'b1;
        forward_i  = 1'b1;
        load_i     = 1'b1;
        load_val_i = 8'h55;
        cycle();
        cycle();
        checkOutput("reset count", count_o, 8'h00);
        checkOutput("reset tick", tick_o, 0);
        checkOutput("reset finish", finish_o, 0);

        // Free run counting up from reset.
        load_i  = 1'b0;
        reset_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            checkOutput($sformatf("run tick c%0d", i), tick_o, (i % 4 == 0) ? 1 : 0);
            checkOutput($sformatf("run count c%0d", i), count_o, i / 4);
        end

        // Up through the top of the range, then a separate digit carry.
        applyStimulus("up98", 8'h98, 8'h98);
        stepAndCheck("up98", 8'h99, 1'b0);
`ifdef BCD_COUNTER_SATURATE_EN
        stepAndCheck("up99", 8'h99, 1'b1);
`else
        stepAndCheck("up99", 8'h00, 1'b1);
`endif
        cycle();
        checkOutput("post wrap finish", finish_o, 0);
        checkOutput("post wrap tick", tick_o, 0);
        applyStimulus("carry", 8'h09, 8'h09);
        stepAndCheck("carry", 8'h10, 1'b0);

        // Down through zero, then a digit borrow.
        forward_i = 1'b0;
        applyStimulus("dn00", 8'h00, 8'h00);
`ifdef BCD_COUNTER_SATURATE_EN
        stepAndCheck("dn00", 8'h00, 1'b1);
`else
        stepAndCheck("dn00", 8'h99, 1'b1);
`endif
        applyStimulus("borrow", 8'h10, 8'h10);
        stepAndCheck("borrow", 8'h09, 1'b0);

        // Enable low for 3 cycles mid-interval delays the step by 3.
        forward_i = 1'b1;
        applyStimulus("pause", 8'h00, 8'h00);
        cycle();
        cycle();
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("pause tick", tick_o, 0);
            checkOutput("pause count", count_o, 8'h00);
        end
        enable_i = 1'b1;
        cycle();
        checkOutput("pause resume tick", tick_o, 0);
        cycle();
        checkOutput("pause step tick", tick_o, 1);
        checkOutput("pause step count", count_o, 8'h01);

        // Non-BCD digits clamp to 9, even with enable low.
        enable_i = 1'b0;
        applyStimulus("clamp", 8'hFA, 8'h99);
        enable_i = 1'b1;

        // Direction change mid-interval affects only the next step.
        applyStimulus("dir", 8'h50, 8'h50);
        cycle();
        cycle();
        forward_i = 1'b0;
        cycle();
        checkOutput("dir quiet tick", tick_o, 0);
        cycle();
        checkOutput("dir step tick", tick_o, 1);
        checkOutput("dir step count", count_o, 8'h49);
        forward_i = 1'b1;

        // Load on a step cycle wins and restarts the interval.
        applyStimulus("ldstep", 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) cycle();
        applyStimulus("ldstep42", 8'h42, 8'h42);
        stepAndCheck("ldstep42", 8'h43, 1'b0);

        // Reset on a step cycle clears everything; restart is a full interval.
        for (int i = 0; i < 3; i++) cycle();
        reset_i = 1'b0;
        cycle();
        checkOutput("rststep count", count_o, 8'h00);
        checkOutput("rststep tick", tick_o, 0);
        checkOutput("rststep finish", finish_o, 0);
        reset_i = 1'b1;
        stepAndCheck("rststep", 8'h01, 1'b0);

`ifdef BCD_COUNTER_SATURATE_EN
        // Saturate at all-9s on repeated up steps.
        applyStimulus("sat", 8'h99, 8'h99);
        stepAndCheck("sat1", 8'h99, 1'b1);
        stepAndCheck("sat2", 8'h99, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
